// File: rtl/kernel_dispatch.sv
// Block dispatcher: splits each core's latched thread count into fixed-size blocks and
// issues them through a reset/start/done handshake. Optional KERNEL_DISPATCH_PERF_EN adds kernel_cycles.
module kernel_dispatch #(
  parameter int NUM_CORES         = 2,
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [NUM_CORES-1:0][7:0]                        thread_count,
  input  logic [NUM_CORES-1:0]                             core_done,
  output logic [NUM_CORES-1:0]                             core_reset,
  output logic [NUM_CORES-1:0]                             core_start,
  output logic [NUM_CORES-1:0][7:0]                        core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0] core_thread_count,
`ifdef KERNEL_DISPATCH_PERF_EN
  output logic [31:0]                                      kernel_cycles,
`endif
  output logic                                             done
);

  localparam int LOG2 = $clog2(THREADS_PER_BLOCK);
  localparam int CW   = LOG2 + 1;
  localparam logic [CW-1:0] TPB_W  = CW'(THREADS_PER_BLOCK);
  localparam logic [15:0]   TPB_16 = 16'(THREADS_PER_BLOCK);
  localparam logic [8:0]    TPB_M1 = 9'(THREADS_PER_BLOCK - 1);

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} global_state_t;
  typedef enum logic [1:0] {C_WAIT, C_LAUNCH, C_BUSY, C_FINISHED} core_state_t;

  global_state_t gstate, gnext;
  logic launch;
  logic run;
  logic [NUM_CORES-1:0] finished;

  always_ff @(posedge clk) begin
    if (reset) gstate <= G_IDLE;
    else       gstate <= gnext;
  end

  always_comb begin
    gnext  = gstate;
    launch = 1'b0;
    case (gstate)
      G_IDLE: if (start) begin
        gnext  = G_RUN;
        launch = 1'b1;
      end
      G_RUN:   if (&finished) gnext = G_DONE;
      G_DONE:  if (!start) gnext = G_IDLE;
      default: gnext = G_IDLE;
    endcase
  end

  assign run  = (gstate == G_RUN);
  assign done = !reset && (gstate == G_DONE);

`ifdef KERNEL_DISPATCH_PERF_EN
  logic [31:0] cycle_q;

  always_ff @(posedge clk) begin
    if (reset)       cycle_q <= '0;
    else if (launch) cycle_q <= '0;
    else if (run)    cycle_q <= cycle_q + 32'd1;
  end

  assign kernel_cycles = reset ? 32'd0 : cycle_q;
`endif

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    core_state_t state, next;
    logic [8:0]    blk, blk_next, blocks;
    logic [7:0]    tc_q, id_q, id_next;
    logic [15:0]   rem;
    logic [CW-1:0] thr;
    logic          issue, active;

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= C_WAIT;
        blk   <= '0;
        tc_q  <= '0;
        id_q  <= '0;
      end else begin
        state <= next;
        blk   <= blk_next;
        id_q  <= id_next;
        if (launch) tc_q <= thread_count[i];
      end
    end

    // blk only moves when leaving BUSY, so id/count derived from it stay stable for the whole block
    always_comb begin
      blocks   = ({1'b0, tc_q} + TPB_M1) >> LOG2;
      rem      = {8'd0, tc_q} - ({7'd0, blk} << LOG2);
      thr      = (rem >= TPB_16) ? TPB_W : rem[CW-1:0];
      issue    = run && (state == C_WAIT) && (blk != blocks);
      active   = issue || (run && ((state == C_LAUNCH) || (state == C_BUSY)));
      next     = state;
      blk_next = blk;
      id_next  = id_q;
      if (launch) begin
        next     = C_WAIT;
        blk_next = '0;
      end else if (run) begin
        case (state)
          C_WAIT: begin
            if (blk == blocks) begin
              next = C_FINISHED;
            end else begin
              next    = C_LAUNCH;
              id_next = blk[7:0];
            end
          end
          C_LAUNCH: next = C_BUSY;
          C_BUSY: if (core_done[i]) begin
            next     = C_WAIT;
            blk_next = blk + 9'd1;
          end
          default: next = C_FINISHED;
        endcase
      end
    end

    assign finished[i]          = (state == C_FINISHED);
    assign core_reset[i]        = !reset && issue;
    assign core_start[i]        = !reset && run && ((state == C_LAUNCH) || (state == C_BUSY));
    assign core_block_id[i]     = reset ? 8'd0 : (active ? blk[7:0] : id_q);
    assign core_thread_count[i] = (!reset && active) ? thr : '0;
  end

endmodule

// File: tb/tb_kernel_dispatch.sv
// Randomized bench for kernel_dispatch: models each core as a handshake partner with random
// service time and predicts block issue, timing and completion from the block arithmetic.
module tb_kernel_dispatch;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int CW  = $clog2(TPB) + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [NC-1:0][7:0]     thread_count;
  logic [NC-1:0]          core_done;
  logic [NC-1:0]          core_reset;
  logic [NC-1:0]          core_start;
  logic [NC-1:0][7:0]     core_block_id;
  logic [NC-1:0][CW-1:0]  core_thread_count;
`ifdef KERNEL_DISPATCH_PERF_EN
  logic [31:0]            kernel_cycles;
`endif
  logic                   done;

  kernel_dispatch #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .thread_count     (thread_count),
    .core_done        (core_done),
    .core_reset       (core_reset),
    .core_start       (core_start),
    .core_block_id    (core_block_id),
    .core_thread_count(core_thread_count),
`ifdef KERNEL_DISPATCH_PERF_EN
    .kernel_cycles    (kernel_cycles),
`endif
    .done             (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Per-core handshake model: 0 waiting for core_reset, 1 launch cycle, 2 running
  int nblk[NC];
  int issued[NC];
  int phase[NC];
  int countdown[NC];
  int nextReset[NC];
  int finishCycle[NC];
  int lastId[NC];
  bit hasIssued[NC];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      if (failures <= 40)
        $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int expCount(input int tc, input int b);
    int r;
    r = tc - b * TPB;
    return (r < TPB) ? r : TPB;
  endfunction

  // Launches a kernel (start already or newly high) and plays the cores until done or timeout
  task automatic applyStimulus(input int tc0, input int tc1, input bit changeMid, output int doneCycle);
    int  tcl[NC];
    int  expDone;
    int  ph;
    int  mx;
    bit  expReset, expStart, allKnown;
    tcl[0] = tc0;
    tcl[1] = tc1;
    thread_count[0] = 8'(tc0);
    thread_count[1] = 8'(tc1);
    reset     = 1'b0;
    start     = 1'b1;
    core_done = '0;
    for (int i = 0; i < NC; i++) begin
      nblk[i]        = (tcl[i] + TPB - 1) / TPB;
      issued[i]      = 0;
      phase[i]       = 0;
      nextReset[i]   = 1;
      finishCycle[i] = (nblk[i] == 0) ? 1 : -1;
      hasIssued[i]   = 1'b0;
    end
    doneCycle = -1;
    expDone   = -1;
    for (int cyc = 1; cyc <= 3000 && doneCycle < 0; cyc++) begin
      @(negedge clk);
      if (changeMid && cyc == 3) begin
        thread_count[0] = 8'd1;
        thread_count[1] = 8'd1;
      end
      for (int i = 0; i < NC; i++) begin
        core_done[i] = 1'b0;
        ph       = phase[i];
        expReset = (ph == 0) && (issued[i] < nblk[i]) && (cyc == nextReset[i]);
        expStart = (ph == 1) || (ph == 2);
        checkOutput($sformatf("core_reset[%0d]@%0d", i, cyc), 32'(core_reset[i]), 32'(expReset));
        checkOutput($sformatf("core_start[%0d]@%0d", i, cyc), 32'(core_start[i]), 32'(expStart));
        if (expReset) begin
          checkOutput($sformatf("block_id[%0d]", i), 32'(core_block_id[i]), issued[i]);
          checkOutput($sformatf("thread_cnt[%0d]", i), 32'(core_thread_count[i]), expCount(tcl[i], issued[i]));
          lastId[i]    = issued[i];
          hasIssued[i] = 1'b1;
          phase[i]     = 1;
        end else if (expStart) begin
          checkOutput($sformatf("block_id_hold[%0d]", i), 32'(core_block_id[i]), lastId[i]);
          checkOutput($sformatf("thread_cnt_hold[%0d]", i), 32'(core_thread_count[i]), expCount(tcl[i], lastId[i]));
          if (ph == 1) begin
            countdown[i] = $urandom_range(1, 5);
            phase[i]     = 2;
          end else begin
            countdown[i]--;
            if (countdown[i] == 0) begin
              core_done[i] = 1'b1;
              issued[i]++;
              phase[i]     = 0;
              nextReset[i] = cyc + 1;
              if (issued[i] == nblk[i]) finishCycle[i] = cyc + 1;
            end
          end
        end else begin
          checkOutput($sformatf("thread_cnt_idle[%0d]", i), 32'(core_thread_count[i]), 0);
          if (hasIssued[i])
            checkOutput($sformatf("block_id_last[%0d]", i), 32'(core_block_id[i]), lastId[i]);
        end
      end
      allKnown = 1'b1;
      mx = 0;
      for (int i = 0; i < NC; i++) begin
        if (finishCycle[i] < 0) allKnown = 1'b0;
        else if (finishCycle[i] > mx) mx = finishCycle[i];
      end
      expDone = allKnown ? mx + 2 : -1;
      checkOutput($sformatf("done@%0d", cyc), 32'(done), 32'(expDone >= 0 && cyc >= expDone));
      if (done === 1'b1) doneCycle = cyc;
    end
    if (doneCycle < 0) checkOutput("kernel_timeout", 0, 1);
    checkOutput("done_cycle", doneCycle, expDone);
    for (int i = 0; i < NC; i++)
      checkOutput($sformatf("blocks_issued[%0d]", i), issued[i], nblk[i]);
`ifdef KERNEL_DISPATCH_PERF_EN
    checkOutput("kernel_cycles", kernel_cycles, doneCycle - 1);
`endif
  endtask

  task automatic finishKernel();
    start = 1'b0;
    @(negedge clk);
    checkOutput("done_clear", 32'(done), 0);
  endtask

  int dc;
  int r0, r1;
  bit reached;

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    thread_count = '0;
    core_done    = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_core_start", 32'(core_start), 0);
    checkOutput("rst_core_reset", 32'(core_reset), 0);
    checkOutput("rst_block_id", 32'(core_block_id), 0);
    checkOutput("rst_thread_cnt", 32'(core_thread_count), 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_done", 32'(done), 0);

    $display("[TB] kernel tc={8,4}");
    applyStimulus(8, 4, 1'b0, dc);
    finishKernel();
    $display("[TB] kernel tc={6,0}");
    applyStimulus(6, 0, 1'b0, dc);
    finishKernel();
    $display("[TB] kernel tc={0,0}");
    applyStimulus(0, 0, 1'b0, dc);
    checkOutput("all_zero_latency", dc, 3);
    finishKernel();
    $display("[TB] kernel tc={8,8} with thread_count change mid-run");
    applyStimulus(8, 8, 1'b1, dc);
    finishKernel();

    $display("[TB] reset while both cores busy");
    thread_count[0] = 8'd8;
    thread_count[1] = 8'd8;
    start   = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      if (core_start === 2'b11) reached = 1'b1;
    end
    checkOutput("reach_both_busy", 32'(reached), 1);
    reset     = 1'b1;
    core_done = '0;
    @(negedge clk);
    checkOutput("abort_core_start", 32'(core_start), 0);
    checkOutput("abort_core_reset", 32'(core_reset), 0);
    checkOutput("abort_block_id", 32'(core_block_id), 0);
    checkOutput("abort_thread_cnt", 32'(core_thread_count), 0);
    checkOutput("abort_done", 32'(done), 0);
    applyStimulus(8, 8, 1'b0, dc);

    $display("[TB] hold start after done, then relaunch");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("hold_done", 32'(done), 1);
      checkOutput("hold_core_start", 32'(core_start), 0);
      checkOutput("hold_core_reset", 32'(core_reset), 0);
    end
    start = 1'b0;
    @(negedge clk);
    checkOutput("drop_done", 32'(done), 0);
    applyStimulus(255, 1, 1'b0, dc);
    finishKernel();

    $display("[TB] random kernels");
    for (int k = 0; k < 6; k++) begin
      r0 = $urandom_range(0, 40);
      r1 = $urandom_range(0, 40);
      applyStimulus(r0, r1, 1'b0, dc);
      finishKernel();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
